// File: rtl/x_bus_caster_pkg.sv
// Shared X-bus definitions: column-tag width helper, tag type and default sizes.
// Used by both the X-bus transmitter and the per-column caster.
package x_bus_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;
    localparam int NUM_COL_DEFAULT    = 4;

    // A single-column bus still needs a 1-bit tag so vectors never collapse to zero width.
    function automatic int col_width(input int num_col);
        return (num_col > 1) ? $clog2(num_col) : 1;
    endfunction

    localparam int CW = col_width(NUM_COL_DEFAULT);

    typedef logic [CW-1:0] col_t;

endpackage

// File: rtl/x_bus_caster_if.sv
// Bus/PE side signals of one caster. The master drives the bus and PE inputs;
// the caster (slave) drives the flow-control, operand and return-path outputs.
interface x_bus_caster_if
    import x_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int NUM_COL    = NUM_COL_DEFAULT,
    localparam int COL_W     = col_width(NUM_COL)
);

    logic                  caster_en;
    logic [COL_W-1:0]      col;
    logic [DATA_WIDTH-1:0] data_b2c;
    logic                  pe_ready;

    logic [DATA_WIDTH-1:0] pe_data;
    logic                  pe_valid;
    logic                  pe_ack;

    logic [DATA_WIDTH-1:0] pe_result;
    logic                  pe_result_valid;
    logic [DATA_WIDTH-1:0] data_c2b;
    logic                  c2b_valid;

    modport master (
        output caster_en, col, data_b2c, pe_ack, pe_result, pe_result_valid,
        input  pe_ready, pe_data, pe_valid, data_c2b, c2b_valid
    );

    modport slave (
        input  caster_en, col, data_b2c, pe_ack, pe_result, pe_result_valid,
        output pe_ready, pe_data, pe_valid, data_c2b, c2b_valid
    );

endinterface

// File: rtl/x_bus_caster_fifo.sv
// Small operand FIFO for the caster: head is read combinationally so a word
// written on one edge is presented to the PE in the very next cycle.
module caster_fifo #(
    parameter int  DATA_WIDTH = 16,
    parameter int  DEPTH      = 2,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [CNT_W-1:0]      count
);

    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    logic full, empty, push_ok, pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
        if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/x_bus_caster.sv
// Column receiver on the X bus: tag match, operand buffering toward the PE,
// sticky overflow on dropped words, and a one-cycle registered result return.
module x_bus_caster
    import x_bus_pkg::*;
#(
    parameter int  DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int  NUM_COL    = NUM_COL_DEFAULT,
    parameter int  DEPTH      = 2,
    localparam int COL_W      = col_width(NUM_COL),
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_id_we,
    input  logic [COL_W-1:0] cfg_id,
    output logic             overflow,
    x_bus_caster_if.slave    bus
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("x_bus_caster: DEPTH must be a power of two and at least 2");
    end

    logic [COL_W-1:0]      id_reg, id_next;
    logic                  overflow_reg, overflow_next;
    logic [DATA_WIDTH-1:0] data_c2b_reg, data_c2b_next;
    logic                  c2b_valid_reg, c2b_valid_next;

    logic [DATA_WIDTH-1:0] head_data;
    logic [CNT_W-1:0]      count;
    logic                  full, empty, hit, push, pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Match uses the ID already held; a same-cycle write only applies next cycle.
    assign hit  = bus.caster_en && (bus.col == id_reg);
    assign push = hit && !full;
    assign pop  = !empty && bus.pe_ack;

    caster_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.data_b2c),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    always_comb begin
        id_next        = id_reg;
        overflow_next  = overflow_reg;
        data_c2b_next  = data_c2b_reg;
        c2b_valid_next = bus.pe_result_valid;
        if (cfg_id_we) id_next = cfg_id;
        // Reprogramming acknowledges the overflow, even against a drop in the same cycle.
        if (cfg_id_we)
            overflow_next = 1'b0;
        else if (hit && full)
            overflow_next = 1'b1;
        if (bus.pe_result_valid) data_c2b_next = bus.pe_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_reg        <= '0;
            overflow_reg  <= 1'b0;
            data_c2b_reg  <= '0;
            c2b_valid_reg <= 1'b0;
        end else begin
            id_reg        <= id_next;
            overflow_reg  <= overflow_next;
            data_c2b_reg  <= data_c2b_next;
            c2b_valid_reg <= c2b_valid_next;
        end
    end

    assign bus.pe_ready  = !full;
    assign bus.pe_valid  = !empty;
    assign bus.pe_data   = head_data;
    assign bus.data_c2b  = data_c2b_reg;
    assign bus.c2b_valid = c2b_valid_reg;
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_x_bus_caster.sv
// Self-checking bench for x_bus_caster: directed scenarios with literal
// expectations plus a randomized phase compared against a queue-based model.
module tb_x_bus_caster;

    localparam int DW    = 16;
    localparam int NCOL  = 4;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_id_we;
    logic [1:0] cfg_id;
    logic       overflow;

    x_bus_caster_if #(.DATA_WIDTH(DW), .NUM_COL(NCOL)) xb ();

    x_bus_caster #(.DATA_WIDTH(DW), .NUM_COL(NCOL), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_id_we (cfg_id_we),
        .cfg_id    (cfg_id),
        .overflow  (overflow),
        .bus       (xb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of buffered operands plus a few scalars.
    logic [DW-1:0] mq[$];
    logic [1:0]    m_id = '0;
    logic          m_ovf = 1'b0;
    logic          m_c2b_v = 1'b0;
    logic [DW-1:0] m_c2b_d = '0;
    logic          m_hit, m_full, m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_id    = '0;
            m_ovf   = 1'b0;
            m_c2b_v = 1'b0;
            m_c2b_d = '0;
        end else begin
            m_hit  = xb.caster_en && (xb.col == m_id);
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() > 0) && xb.pe_ack;
            if (m_pop) $display("[%0t] pop    %h", $time, mq.pop_front());
            if (m_hit && !m_full) begin
                mq.push_back(xb.data_b2c);
                $display("[%0t] push   %h", $time, xb.data_b2c);
            end
            if (m_hit && m_full) $display("[%0t] drop   %h", $time, xb.data_b2c);
            if (cfg_id_we) m_ovf = 1'b0;
            else if (m_hit && m_full) m_ovf = 1'b1;
            if (cfg_id_we) m_id = cfg_id;
            m_c2b_v = xb.pe_result_valid;
            if (xb.pe_result_valid) begin
                m_c2b_d = xb.pe_result;
                $display("[%0t] result %h", $time, xb.pe_result);
            end
        end
    end

    // Outputs depend only on registered state, so the opposite edge is a stable sample point.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_pe_ready", 32'(xb.pe_ready), 32'(mq.size() < DEPTH));
            chk("model_pe_valid", 32'(xb.pe_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("model_pe_data", 32'(xb.pe_data), 32'(mq[0]));
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
            chk("model_c2b_valid", 32'(xb.c2b_valid), 32'(m_c2b_v));
            chk("model_data_c2b", 32'(xb.data_c2b), 32'(m_c2b_d));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] c, input logic [DW-1:0] d);
        xb.caster_en = 1'b1;
        xb.col       = c;
        xb.data_b2c  = d;
        step();
        xb.caster_en = 1'b0;
    endtask

    task automatic program_id(input logic [1:0] id);
        cfg_id_we = 1'b1;
        cfg_id    = id;
        step();
        cfg_id_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int r;
        cfg_id_we = 1'b0; cfg_id = '0;
        xb.caster_en = 1'b0; xb.col = '0; xb.data_b2c = '0;
        xb.pe_ack = 1'b0; xb.pe_result = '0; xb.pe_result_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;

        chk("reset_pe_ready", 32'(xb.pe_ready), 32'd1);
        chk("reset_pe_valid", 32'(xb.pe_valid), 32'd0);
        chk("reset_c2b_valid", 32'(xb.c2b_valid), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_data_c2b", 32'(xb.data_c2b), 32'd0);

        program_id(2'd2);
        send(2'd2, 16'h1234);
        chk("single_pe_valid", 32'(xb.pe_valid), 32'd1);
        chk("single_pe_data", 32'(xb.pe_data), 32'h1234);
        xb.pe_ack = 1'b1; step(); xb.pe_ack = 1'b0;
        chk("single_drained", 32'(xb.pe_valid), 32'd0);
        send(2'd1, 16'h5555);
        chk("miss_pe_valid", 32'(xb.pe_valid), 32'd0);

        send(2'd2, 16'h00A1);
        send(2'd2, 16'h00A2);
        chk("fill_pe_ready", 32'(xb.pe_ready), 32'd0);
        send(2'd2, 16'h00A3);
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_head", 32'(xb.pe_data), 32'h00A1);
        xb.pe_ack = 1'b1; step();
        chk("fill_second", 32'(xb.pe_data), 32'h00A2);
        step(); xb.pe_ack = 1'b0;
        chk("fill_empty", 32'(xb.pe_valid), 32'd0);
        chk("fill_ready_back", 32'(xb.pe_ready), 32'd1);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        program_id(2'd2);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Clear beats a simultaneous drop.
        send(2'd2, 16'h00B1);
        send(2'd2, 16'h00B2);
        cfg_id_we = 1'b1; cfg_id = 2'd2;
        send(2'd2, 16'h00B3);
        cfg_id_we = 1'b0;
        chk("clear_wins", 32'(overflow), 32'd0);
        xb.pe_ack = 1'b1; step(); step(); xb.pe_ack = 1'b0;

        // New ID only matches from the following cycle.
        cfg_id_we = 1'b1; cfg_id = 2'd3;
        send(2'd3, 16'h00C1);
        cfg_id_we = 1'b0;
        chk("id_same_cycle", 32'(xb.pe_valid), 32'd0);
        send(2'd3, 16'h00C2);
        chk("id_next_cycle", 32'(xb.pe_data), 32'h00C2);
        xb.pe_ack = 1'b1; step(); xb.pe_ack = 1'b0;
        program_id(2'd2);

        xb.pe_ack = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            xb.caster_en = 1'b1; xb.col = 2'd2; xb.data_b2c = 16'(i);
            step();
            chk("stream_data", 32'(xb.pe_data), 32'(i));
            chk("stream_ready", 32'(xb.pe_ready), 32'd1);
        end
        xb.caster_en = 1'b0;
        step();
        xb.pe_ack = 1'b0;
        chk("stream_done", 32'(xb.pe_valid), 32'd0);

        xb.pe_result_valid = 1'b1; xb.pe_result = 16'hBEEF; step();
        chk("ret_beef", 32'(xb.data_c2b), 32'hBEEF);
        chk("ret_beef_v", 32'(xb.c2b_valid), 32'd1);
        xb.pe_result = 16'hCAFE; step();
        chk("ret_cafe", 32'(xb.data_c2b), 32'hCAFE);
        chk("ret_cafe_v", 32'(xb.c2b_valid), 32'd1);
        xb.pe_result_valid = 1'b0; xb.pe_result = 16'h0000; step();
        chk("ret_idle_v", 32'(xb.c2b_valid), 32'd0);
        chk("ret_hold", 32'(xb.data_c2b), 32'hCAFE);

        send(2'd2, 16'h0077);
        chk("rst_buffered", 32'(xb.pe_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_valid", 32'(xb.pe_valid), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk("rst_after_valid", 32'(xb.pe_valid), 32'd0);
        chk("rst_after_ready", 32'(xb.pe_ready), 32'd1);
        program_id(2'd1);

        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            xb.caster_en = (mq.size() < DEPTH) ? (r < 70) : (r < 10);
            xb.col = ($urandom_range(0, 99) < 60) ? m_id : 2'($urandom_range(0, 3));
            xb.data_b2c = 16'($urandom);
            cfg_id_we = ($urandom_range(0, 99) < 4);
            cfg_id = 2'($urandom_range(0, 3));
            xb.pe_ack = ($urandom_range(0, 99) < 50);
            xb.pe_result_valid = ($urandom_range(0, 99) < 40);
            xb.pe_result = 16'($urandom);
            step();
        end
        xb.caster_en = 1'b0; cfg_id_we = 1'b0; xb.pe_result_valid = 1'b0;
        xb.pe_ack = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
